// File: rtl/barrett_param_gen.sv
// Barrett parameter generator: computes mu = floor(2^(2k)/m) and k = bitlength(m) for modulus m.
// Latency: 2k+2 cycles from accepting edge to finish_o for supported m, 2 cycles for unsupported m.
// Backpressure: none; start_i is honoured only in IDLE, ignored while busy. Option macro: BARRETT_PARAM_REM_EN (adds rem_o).
module barrett_param_gen #(
    parameter int DATA_LENGTH = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [DATA_LENGTH-1:0] m_i,
    output logic                   busy_o,
    output logic                   finish_o,
    output logic [DATA_LENGTH-1:0] mu_o,
    output logic [DATA_LENGTH-1:0] m_bl_o,
    output logic                   error_o
`ifdef BARRETT_PARAM_REM_EN
    ,
    output logic [DATA_LENGTH-1:0] rem_o
`endif
);

    // Iteration counter must hold 2k, and k never exceeds DATA_LENGTH-1 for a supported modulus.
    localparam int CW = $clog2(2 * DATA_LENGTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]             r_state;
    logic [DATA_LENGTH-1:0] r_m;
    logic [DATA_LENGTH-1:0] r_k;
    logic [DATA_LENGTH-1:0] r_rem;
    logic [DATA_LENGTH-2:0] r_q;
    logic [CW-1:0]          r_cnt;
    logic                   r_first;
    logic                   r_err_pend;
    logic [DATA_LENGTH-1:0] r_mu;
    logic [DATA_LENGTH-1:0] r_bl;
    logic                   r_err;
`ifdef BARRETT_PARAM_REM_EN
    logic [DATA_LENGTH-1:0] r_rem_out;
`endif

    logic [DATA_LENGTH-1:0] w_k;
    logic                   w_unsup;
    logic [DATA_LENGTH:0]   w_rem_sh;
    logic                   w_ge;
    logic [DATA_LENGTH-1:0] w_rem_nx;
    logic [DATA_LENGTH-1:0] w_q_nx;
    logic                   w_last;
    logic                   w_err_fin;

    // Bit length of the registered modulus: index of the highest set bit plus one.
    always_comb begin
        w_k = '0;
        for (int i = 0; i < DATA_LENGTH; i++) begin
            if (r_m[i]) begin
                w_k = DATA_LENGTH'(i + 1);
            end
        end
    end

    // Zero has no inverse and a set top bit would make 2^(2k) overflow the datapath.
    assign w_unsup = (r_m == '0) || r_m[DATA_LENGTH-1];

    // One restoring-division step. The shifted remainder carries one extra bit so the shift
    // cannot overflow; after the conditional subtract it is always below m and fits back.
    assign w_rem_sh = {r_rem, r_first};
    assign w_ge     = (w_rem_sh >= {1'b0, r_m});
    assign w_rem_nx = w_ge ? DATA_LENGTH'(w_rem_sh - {1'b0, r_m}) : w_rem_sh[DATA_LENGTH-1:0];
    assign w_q_nx   = {r_q, w_ge};

    assign w_last    = (r_state == S_DIV) && (r_cnt == '0);
    // Unsupported moduli spend a second LOAD cycle so the error answer lands two cycles after acceptance.
    assign w_err_fin = (r_state == S_LOAD) && w_unsup && r_err_pend;

    // Control FSM and division datapath.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_m        <= '0;
            r_k        <= '0;
            r_rem      <= '0;
            r_q        <= '0;
            r_cnt      <= '0;
            r_first    <= 1'b0;
            r_err_pend <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_m        <= m_i;
                        r_err_pend <= 1'b0;
                        r_state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_k     <= w_k;
                    r_rem   <= '0;
                    r_q     <= '0;
                    r_cnt   <= {w_k[CW-2:0], 1'b0};
                    r_first <= 1'b1;
                    if (!w_unsup) begin
                        r_state <= S_DIV;
                    end else if (r_err_pend) begin
                        r_state <= S_DONE;
                    end else begin
                        r_err_pend <= 1'b1;
                    end
                end
                S_DIV: begin
                    r_rem   <= w_rem_nx;
                    r_q     <= w_q_nx[DATA_LENGTH-2:0];
                    r_first <= 1'b0;
                    r_cnt   <= r_cnt - CW'(1);
                    if (r_cnt == '0) begin
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Result registers: loaded on the edge that enters DONE, held until the next DONE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mu  <= '0;
            r_bl  <= '0;
            r_err <= 1'b0;
`ifdef BARRETT_PARAM_REM_EN
            r_rem_out <= '0;
`endif
        end else if (w_last) begin
            r_mu  <= w_q_nx;
            r_bl  <= r_k;
            r_err <= 1'b0;
`ifdef BARRETT_PARAM_REM_EN
            r_rem_out <= w_rem_nx;
`endif
        end else if (w_err_fin) begin
            r_mu  <= '0;
            r_bl  <= '0;
            r_err <= 1'b1;
`ifdef BARRETT_PARAM_REM_EN
            r_rem_out <= '0;
`endif
        end
    end

    assign busy_o   = (r_state == S_LOAD) || (r_state == S_DIV);
    assign finish_o = (r_state == S_DONE);
    assign mu_o     = r_mu;
    assign m_bl_o   = r_bl;
    assign error_o  = r_err;
`ifdef BARRETT_PARAM_REM_EN
    assign rem_o    = r_rem_out;
`endif

endmodule

// File: doc/barrett_param_gen.md
BARRETT_PARAM_GEN -- requirements
Module: barrett_param_gen

Interface
REQ-001 SHALL have parameter DATA_LENGTH, default 64 (multiplier_pkg value), width of the m_i, mu_o and m_bl_o ports.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start_i, input, 1, request to compute parameters for m_i.
REQ-005 SHALL have port m_i, input, DATA_LENGTH, modulus; sampled only on the accepting edge.
REQ-006 SHALL have port busy_o, output, 1, high while a computation is in progress.
REQ-007 SHALL have port finish_o, output, 1, single-cycle pulse marking valid results.
REQ-008 SHALL have port mu_o, output, DATA_LENGTH, Barrett constant floor(2^(2k)/m).
REQ-009 SHALL have port m_bl_o, output, DATA_LENGTH, modulus bit length k, zero-extended.
REQ-010 SHALL have port error_o, output, 1, high alongside finish_o when m_i is unsupported.

Function
REQ-011 SHALL have states IDLE, LOAD, DIV and DONE.
REQ-012 SHALL accept start only in IDLE; start_i in any other state is ignored and m_i is not resampled.
REQ-013 SHALL, on the accepting edge E0, register m_i, go to LOAD, and set busy_o high from E0.
REQ-014 SHALL, in LOAD, set k = floor(log2 m)+1 (a power of two 2^j gives k=j+1), clear the remainder and quotient, and load the iteration counter with 2k.
REQ-015 SHALL, in LOAD, treat m==0 or m>=2^(DATA_LENGTH-1) as unsupported and go directly to DONE with error_o=1, mu_o=0, m_bl_o=0.
REQ-016 SHALL, in DIV, run restoring division of 2^(2k) by m at one quotient bit per cycle, MSB first, for exactly 2k+1 cycles: shift the next dividend bit into the remainder (1 on the first iteration, 0 after), subtract m if the remainder is >= m, and shift the result bit into the quotient.
REQ-017 SHALL size the remainder at DATA_LENGTH+1 bits so the shift never overflows.
REQ-018 SHALL go to DONE after the last DIV iteration; in DONE, finish_o=1, busy_o=0, and mu_o, m_bl_o and error_o are valid; the next state is IDLE.
REQ-019 SHALL assert finish_o exactly 2k+2 cycles after E0 for a supported m, and exactly 2 cycles after E0 for an unsupported m.
REQ-020 SHALL hold mu_o, m_bl_o and error_o until the next DONE; busy_o and finish_o are never high together.

Reset
REQ-021 SHALL, on rst_i high in any state including mid-DIV, go to IDLE immediately and clear busy_o, finish_o, error_o, mu_o, m_bl_o and all internal registers.
REQ-022 SHALL accept a new start on the first rising edge after rst_i is released.

Configuration
REQ-023 SHALL, when BARRETT_PARAM_REM_EN is defined, add output rem_o (DATA_LENGTH wide, reset 0) carrying the final remainder 2^(2k) mod m, updated in DONE and forced to 0 on error.
REQ-024 SHALL, when BARRETT_PARAM_REM_EN is undefined, have no rem_o port or remainder output register, with all other behaviour identical.

Verification
REQ-025 SHALL verify: m_i=0x7FE001 -> m_bl_o=23, mu_o=0x802007, error_o=0, finish_o 48 cycles after E0, rem_o=0xBFF9 when enabled.
REQ-026 SHALL verify: m_i=0xD01 -> m_bl_o=12, mu_o=0x13AF, finish_o 26 cycles after E0, rem_o=0x951 when enabled.
REQ-027 SHALL verify: m_i=0 and m_i=2^(DATA_LENGTH-1) -> error_o=1, mu_o=0, m_bl_o=0, finish_o 2 cycles after E0.
REQ-028 SHALL verify: m_i=1 -> k=1, mu_o=4; m_i=0x80 -> k=8, mu_o=0x200; rem_o=0 in both cases.
REQ-029 SHALL verify: start_i pulsed with a different m_i mid-DIV -> ignored, and the original result is delivered on schedule.
REQ-030 SHALL verify: rst_i asserted 10 cycles into DIV -> all outputs 0 in the same cycle, and a fresh start after release completes correctly.
